// File: rtl/flopwb.sv
// ---------------------------------------------------------------------------
// flopwb : MEM/WB pipeline register of the 32-bit core.
//
// Captures the memory-stage control bits, destination register index, ALU
// result and load data on every rising clock edge, and presents them to the
// writeback stage one cycle later. A synchronous flush injects a bubble
// (all fields zero, so RegWriteW=0 and PCSrcW=0 give no architectural effect).
//
// Optional feature macro: FLOPWB_STALL_EN
//   defined   -> extra input 'stall' (after flush); when stall=1 and flush=0
//                every output holds its current value.
//   undefined -> no stall port; the register captures every cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active-low (0 clears every output)
//   prsrc      PC-source control from MEM          -> PCSrcW
//   regwrite   register-write enable from MEM      -> RegWriteW
//   memtoreg   writeback-mux select from MEM       -> MemtoRegW
//   wa3m       destination register index from MEM -> WA3W
//   Aludata    ALU result from MEM (WIDTH bits)    -> ALUOutW
//   readData   data-memory read value (WIDTH bits) -> ReadDataW
//   flush      synchronous bubble insert, active-high
//   stall      hold current contents, active-high (FLOPWB_STALL_EN only)
//
// Priority: reset > flush > stall > capture. Fields pass bit-exact; X on an
// input is captured as-is rather than masked.
// ---------------------------------------------------------------------------
module flopwb #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             prsrc,
    input  logic             regwrite,
    input  logic             memtoreg,
    input  logic [3:0]       wa3m,
    input  logic [WIDTH-1:0] Aludata,
    input  logic [WIDTH-1:0] readData,
    output logic [WIDTH-1:0] ReadDataW,
    output logic [WIDTH-1:0] ALUOutW,
    output logic             PCSrcW,
    output logic             RegWriteW,
    output logic             MemtoRegW,
    output logic [3:0]       WA3W,
    input  logic             flush
`ifdef FLOPWB_STALL_EN
    ,
    input  logic             stall
`endif
);

    logic             hold_s;
    logic [WIDTH-1:0] read_data_s;
    logic [WIDTH-1:0] alu_out_s;
    logic             pc_src_s;
    logic             reg_write_s;
    logic             mem_to_reg_s;
    logic [3:0]       wa3_s;

`ifdef FLOPWB_STALL_EN
    assign hold_s = stall;
`else
    assign hold_s = 1'b0;
`endif

    // Next-state selection: flush bubble beats stall hold, which beats capture.
    always_comb begin
        read_data_s  = readData;
        alu_out_s    = Aludata;
        pc_src_s     = prsrc;
        reg_write_s  = regwrite;
        mem_to_reg_s = memtoreg;
        wa3_s        = wa3m;
        if (flush) begin
            read_data_s  = {WIDTH{1'b0}};
            alu_out_s    = {WIDTH{1'b0}};
            pc_src_s     = 1'b0;
            reg_write_s  = 1'b0;
            mem_to_reg_s = 1'b0;
            wa3_s        = 4'h0;
        end else if (hold_s) begin
            read_data_s  = ReadDataW;
            alu_out_s    = ALUOutW;
            pc_src_s     = PCSrcW;
            reg_write_s  = RegWriteW;
            mem_to_reg_s = MemtoRegW;
            wa3_s        = WA3W;
        end else begin
            read_data_s  = readData;
            alu_out_s    = Aludata;
            pc_src_s     = prsrc;
            reg_write_s  = regwrite;
            mem_to_reg_s = memtoreg;
            wa3_s        = wa3m;
        end
    end

    // Pipeline register; outputs come straight from these flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ReadDataW <= {WIDTH{1'b0}};
            ALUOutW   <= {WIDTH{1'b0}};
            PCSrcW    <= 1'b0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            WA3W      <= 4'h0;
        end else begin
            ReadDataW <= read_data_s;
            ALUOutW   <= alu_out_s;
            PCSrcW    <= pc_src_s;
            RegWriteW <= reg_write_s;
            MemtoRegW <= mem_to_reg_s;
            WA3W      <= wa3_s;
        end
    end

endmodule

// File: tb/tb_flopwb.sv
// ---------------------------------------------------------------------------
// tb_flopwb : self-checking bench for flopwb (32-bit instance plus a 16-bit
// instance). Table-driven vectors for pass-through/streaming/flush, plus
// hand-written sequences for reset, mid-cycle reset, stall and WIDTH=16.
// ---------------------------------------------------------------------------
module tb_flopwb;

    logic        clk = 1'b0;
    logic        reset;
    logic        prsrc, regwrite, memtoreg, flush;
    logic [3:0]  wa3m;
    logic [31:0] Aludata, readData;
    logic [31:0] ReadDataW, ALUOutW;
    logic        PCSrcW, RegWriteW, MemtoRegW;
    logic [3:0]  WA3W;

    logic [15:0] alu16, rd16, ALUOutW16, ReadDataW16;
    logic        p16, r16, m16;
    logic [3:0]  w16;

`ifdef FLOPWB_STALL_EN
    logic stall;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flopwb #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .prsrc(prsrc), .regwrite(regwrite),
        .memtoreg(memtoreg), .wa3m(wa3m), .Aludata(Aludata), .readData(readData),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .PCSrcW(PCSrcW),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .WA3W(WA3W),
        .flush(flush)
`ifdef FLOPWB_STALL_EN
        , .stall(stall)
`endif
    );

    flopwb #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .prsrc(1'b1), .regwrite(1'b1),
        .memtoreg(1'b1), .wa3m(4'h9), .Aludata(alu16), .readData(rd16),
        .ReadDataW(ReadDataW16), .ALUOutW(ALUOutW16), .PCSrcW(p16),
        .RegWriteW(r16), .MemtoRegW(m16), .WA3W(w16),
        .flush(flush)
`ifdef FLOPWB_STALL_EN
        , .stall(1'b0)
`endif
    );

    typedef struct {
        logic        p, r, m, f;
        logic [3:0]  w;
        logic [31:0] a, d;
        logic [70:0] exp;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [70:0] pk(input logic p, input logic r, input logic m,
                                       input logic [3:0] w, input logic [31:0] a,
                                       input logic [31:0] d);
        return {p, r, m, w, a, d};
    endfunction

    function automatic logic [70:0] outs();
        return {PCSrcW, RegWriteW, MemtoRegW, WA3W, ALUOutW, ReadDataW};
    endfunction

    task automatic chk(input string nm, input logic [70:0] act, input logic [70:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic p, input logic r, input logic m, input logic [3:0] w,
                         input logic [31:0] a, input logic [31:0] d, input logic f);
        prsrc = p; regwrite = r; memtoreg = m; wa3m = w;
        Aludata = a; readData = d; flush = f;
    endtask

    task automatic setv(input int i, input logic p, input logic r, input logic m,
                        input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                        input logic f, input logic [70:0] e);
        vecs[i].p = p; vecs[i].r = r; vecs[i].m = m; vecs[i].w = w;
        vecs[i].a = a; vecs[i].d = d; vecs[i].f = f; vecs[i].exp = e;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // pass-through, five-vector stream, flush and recapture
        setv(0, 1'b1, 1'b1, 1'b0, 4'hA, 32'h12345678, 32'hDEADBEEF, 1'b0,
             pk(1'b1, 1'b1, 1'b0, 4'hA, 32'h12345678, 32'hDEADBEEF));
        setv(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h00000000, 32'h00000000, 1'b0,
             pk(1'b0, 1'b0, 1'b0, 4'h0, 32'h00000000, 32'h00000000));
        setv(2, 1'b1, 1'b1, 1'b1, 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
             pk(1'b1, 1'b1, 1'b1, 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF));
        setv(3, 1'b0, 1'b1, 1'b1, 4'h3, 32'h00000001, 32'h80000000, 1'b0,
             pk(1'b0, 1'b1, 1'b1, 4'h3, 32'h00000001, 32'h80000000));
        setv(4, 1'b1, 1'b0, 1'b0, 4'hC, 32'hCAFEF00D, 32'h0BADC0DE, 1'b0,
             pk(1'b1, 1'b0, 1'b0, 4'hC, 32'hCAFEF00D, 32'h0BADC0DE));
        setv(5, 1'b1, 1'b1, 1'b1, 4'h5, 32'hAAAA5555, 32'h5555AAAA, 1'b0,
             pk(1'b1, 1'b1, 1'b1, 4'h5, 32'hAAAA5555, 32'h5555AAAA));
        setv(6, 1'b1, 1'b1, 1'b0, 4'h7, 32'h13579BDF, 32'h2468ACE0, 1'b1,
             pk(1'b0, 1'b0, 1'b0, 4'h0, 32'h00000000, 32'h00000000));
        setv(7, 1'b1, 1'b1, 1'b0, 4'h7, 32'h13579BDF, 32'h2468ACE0, 1'b0,
             pk(1'b1, 1'b1, 1'b0, 4'h7, 32'h13579BDF, 32'h2468ACE0));
        setv(8, 1'b0, 1'b1, 1'b0, 4'h2, 32'h00000042, 32'h00000024, 1'b0,
             pk(1'b0, 1'b1, 1'b0, 4'h2, 32'h00000042, 32'h00000024));
        setv(9, 1'b1, 1'b1, 1'b1, 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
             pk(1'b0, 1'b0, 1'b0, 4'h0, 32'h00000000, 32'h00000000));

        // reset held low across two edges with all-ones inputs
        reset = 1'b0;
        alu16 = 16'h0000; rd16 = 16'h0000;
`ifdef FLOPWB_STALL_EN
        stall = 1'b0;
`endif
        drive(1'b1, 1'b1, 1'b1, 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk($sformatf("reset_hold_%0d", i), outs(), 71'd0);
        end
        #3 reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].p, vecs[i].r, vecs[i].m, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].f);
            @(posedge clk); #1;
            chk($sformatf("vec_%0d", i), outs(), vecs[i].exp);
        end

        // mid-cycle asynchronous reset after loading data
        drive(1'b1, 1'b0, 1'b1, 4'h6, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0);
        @(posedge clk); #1;
        chk("load_before_async", outs(), pk(1'b1, 1'b0, 1'b1, 4'h6, 32'h0F0F0F0F, 32'hF0F0F0F0));
        #2 reset = 1'b0;
        #1;
        chk("async_reset_midcycle", outs(), 71'd0);
        @(posedge clk); #1;
        chk("reset_low_edge", outs(), 71'd0);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        chk("first_capture_after_release", outs(),
            pk(1'b1, 1'b0, 1'b1, 4'h6, 32'h0F0F0F0F, 32'hF0F0F0F0));

`ifdef FLOPWB_STALL_EN
        // capture V1, stall three edges with changing inputs, then stall+flush
        drive(1'b1, 1'b1, 1'b0, 4'hB, 32'h11112222, 32'h33334444, 1'b0);
        @(posedge clk); #1;
        chk("stall_v1", outs(), pk(1'b1, 1'b1, 1'b0, 4'hB, 32'h11112222, 32'h33334444));
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i[0], 1'b0, 1'b1, 4'(i + 1), 32'hA0000000 + 32'(i), 32'h0000000B + 32'(i), 1'b0);
            @(posedge clk); #1;
            chk($sformatf("stall_hold_%0d", i), outs(),
                pk(1'b1, 1'b1, 1'b0, 4'hB, 32'h11112222, 32'h33334444));
        end
        flush = 1'b1;
        @(posedge clk); #1;
        chk("stall_flush", outs(), 71'd0);
        stall = 1'b0;
        flush = 1'b0;
`endif

        // 16-bit instance: no sign/zero extension artefacts
        alu16 = 16'h8001; rd16 = 16'h7FFE; flush = 1'b0;
        @(posedge clk); #1;
        chk("w16_alu", {55'd0, ALUOutW16}, {55'd0, 16'h8001});
        chk("w16_rd", {55'd0, ReadDataW16}, {55'd0, 16'h7FFE});
        chk("w16_ctrl", {64'd0, p16, r16, m16, w16}, {64'd0, 1'b1, 1'b1, 1'b1, 4'h9});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flopwb.md
Name: flopwb

Overview:
- Memory-to-writeback (MEM/WB) pipeline register of the 32-bit core.
- Captures the memory-stage control bits, destination register index, ALU result and load data on each rising clock edge.
- Presents them to the writeback stage one cycle later.
- Also supports a synchronous flush that injects a bubble.

Parameters:
- WIDTH, 32, datapath width of the ALU-result and read-data fields (legal range 8..64).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous reset, active-low (0 = reset asserted)
- prsrc  input  1  PC-source control from MEM stage
- regwrite  input  1  register-write enable from MEM stage
- memtoreg  input  1  writeback-mux select from MEM stage (1 = load data)
- wa3m  input  4  destination register index from MEM stage
- Aludata  input  WIDTH  ALU result from MEM stage
- readData  input  WIDTH  data-memory read value from MEM stage
- ReadDataW  output  WIDTH  registered readData
- ALUOutW  output  WIDTH  registered Aludata
- PCSrcW  output  1  registered prsrc
- RegWriteW  output  1  registered regwrite
- MemtoRegW  output  1  registered memtoreg
- WA3W  output  4  registered wa3m
- flush  input  1  synchronous bubble insert, active-high

Port order is exactly as listed. flush and the optional stall port follow WA3W.

Behaviour:
- All outputs are driven directly from flops; no combinational input-to-output path.
- Reset:
  - reset=0 asynchronously clears every output to 0, immediately and regardless of clk.
  - While reset=0, outputs stay 0.
  - First capture happens on the first rising edge with reset=1.
  - Deassertion is not internally synchronised; the system reset controller releases it.
- Normal operation: on each rising edge with reset=1 and flush=0, every output takes its corresponding input value. Latency is exactly 1 cycle.
- Flush: on a rising edge with flush=1, all outputs load 0.
  - The bubble has RegWriteW=0 and PCSrcW=0, so it has no architectural effect.
  - Data fields are cleared as well.
- No arithmetic is performed; fields pass through bit-exact at WIDTH bits with no sign or zero extension.
- Priority: reset > flush > stall (optional) > capture.
- X on inputs propagates to outputs unchanged; X is not masked.

Optional Feature:
- Macro: FLOPWB_STALL_EN
- Defined:
  - Adds input port stall (1 bit, active-high) after flush.
  - On a rising edge with reset=1, flush=0, stall=1, all outputs hold their current values.
  - flush=1 overrides stall.
- Undefined:
  - No stall port exists.
  - The register captures every cycle; behaviour is identical to defined-with-stall tied 0.

Test Plan:
- Reset: hold reset=0 for 2 edges with inputs all 1s -> all outputs 0. Assert reset=0 mid-cycle after loading data -> outputs 0 immediately, before the next edge.
- Pass-through: release reset, then drive prsrc=1, regwrite=1, memtoreg=0, wa3m=4'hA, Aludata=32'h12345678, readData=32'hDEADBEEF -> after the next rising edge, {PCSrcW,RegWriteW,MemtoRegW,WA3W,ALUOutW,ReadDataW} = 1,1,0,A,12345678,DEADBEEF.
- Streaming: apply 5 consecutive distinct vectors, including all-zero and all-one (wa3m=4'hF, data 32'hFFFFFFFF) -> each appears on the outputs exactly one edge later, in order, with no drops or duplicates.
- Flush: with register holding 1,1,1,5,AAAA5555,5555AAAA, assert flush=1 for one edge with new non-zero inputs -> all outputs 0. Next edge with flush=0 -> the new inputs are captured.
- Stall (FLOPWB_STALL_EN defined): capture vector V1, then stall=1 for 3 edges while inputs change -> outputs remain V1. stall=1 with flush=1 -> outputs 0.
- WIDTH=16 build: Aludata=16'h8001, readData=16'h7FFE -> ALUOutW=8001, ReadDataW=7FFE after one edge; no extension artefacts.
